// File: rtl/alu_core.sv
// Registered integer ALU for the execute stage: AND/OR/ADD/SRL/SRA/BEQ/address-add.
// Latency 1 cycle, one op accepted every cycle; no handshake, so no backpressure.
module alu_core #(
    parameter int reg_width = 8,
    parameter int op_width  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [reg_width-1:0] ra_in,
    input  logic [reg_width-1:0] rb_in,
    input  logic [op_width-1:0]  op,
    output logic [reg_width-1:0] res_out,
    output logic [reg_width-1:0] car_out,
    output logic                 zero,
    output logic                 jump
);

    localparam logic [op_width-1:0] OP_AND = op_width'(0);
    localparam logic [op_width-1:0] OP_OR  = op_width'(1);
    localparam logic [op_width-1:0] OP_ADD = op_width'(2);
    localparam logic [op_width-1:0] OP_SRL = op_width'(3);
    localparam logic [op_width-1:0] OP_SRA = op_width'(4);
    localparam logic [op_width-1:0] OP_BEQ = op_width'(5);
    localparam logic [op_width-1:0] OP_ADR = op_width'(6);

    logic [reg_width-1:0]   res_d, res_q;
    logic [reg_width-1:0]   car_d, car_q;
    logic                   zero_d, zero_q;
    logic                   jump_d, jump_q;

    logic [reg_width:0]     add_w;
    logic                   ovf_w;
    logic [2*reg_width-1:0] shout_w;

    // Carry-out is the extra top bit; overflow when equal-sign operands give a different-sign sum.
    assign add_w   = {1'b0, ra_in} + {1'b0, rb_in};
    assign ovf_w   = (ra_in[reg_width-1] == rb_in[reg_width-1]) &&
                     (add_w[reg_width-1] != ra_in[reg_width-1]);
    // Bits pushed out by a right shift land MSB-aligned in the low half.
    assign shout_w = {ra_in, {reg_width{1'b0}}} >> rb_in;

    always_comb begin
        res_d  = '0;
        car_d  = '0;
        jump_d = 1'b0;
        case (op)
            OP_AND: res_d = ra_in & rb_in;
            OP_OR:  res_d = ra_in | rb_in;
            OP_ADD: begin
                res_d = add_w[reg_width-1:0];
                car_d = {{(reg_width-2){1'b0}}, ovf_w, add_w[reg_width]};
            end
            OP_SRL: begin
                res_d = ra_in >> rb_in;
                car_d = shout_w[reg_width-1:0];
            end
            OP_SRA: begin
                res_d = $signed(ra_in) >>> rb_in;
                car_d = shout_w[reg_width-1:0];
            end
            OP_BEQ: begin
                res_d  = ra_in - rb_in;
                jump_d = (ra_in == rb_in);
            end
            OP_ADR: res_d = ra_in + rb_in;
            default: ;
        endcase
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            car_q  <= '0;
            zero_q <= 1'b0;
            jump_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            car_q  <= car_d;
            zero_q <= zero_d;
            jump_q <= jump_d;
        end
    end

    assign res_out = res_q;
    assign car_out = car_q;
    assign zero    = zero_q;
    assign jump    = jump_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: expected outputs queued at drive time, popped after the edge.
module tb_alu_core;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] car;
        logic       zero;
        logic       jump;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ra_in, rb_in;
    logic [2:0] op;
    logic [7:0] res_out, car_out;
    logic       zero, jump;

    exp_t sb[$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;

    alu_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra_in  (ra_in),
        .rb_in  (rb_in),
        .op     (op),
        .res_out(res_out),
        .car_out(car_out),
        .zero   (zero),
        .jump   (jump)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] r, input logic [7:0] c,
                                input logic z, input logic j);
        exp_t e;
        e.res = r; e.car = c; e.zero = z; e.jump = j;
        return e;
    endfunction

    task automatic check(input string tag, input exp_t e);
        exp_t o;
        o = {res_out, car_out, zero, jump};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got res=%h car=%h zero=%b jump=%b, expected res=%h car=%h zero=%b jump=%b",
                   tag, o.res, o.car, o.zero, o.jump, e.res, e.car, e.zero, e.jump);
        end
    endtask

    // Drive at the falling edge, queue the prediction, pop and compare just after the next rising edge.
    task automatic pop_check(input string tag);
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty, no prediction queued", tag);
        end else begin
            last_exp = sb.pop_front();
            check(tag, last_exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [7:0] ec,
                        input logic ez, input logic ej);
        @(negedge clk);
        op = o; ra_in = a; rb_in = b;
        sb.push_back(mk(er, ec, ez, ej));
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        op = 3'd2; ra_in = 8'h7F; rb_in = 8'h7F;
        #12;
        check("reset_state", mk(8'h00, 8'h00, 1'b0, 1'b0));
        rst_n = 1'b1;

        step("and_ff_3c",  3'd0, 8'hFF, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0);
        step("or_ff_3c",   3'd1, 8'hFF, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0);
        step("and_c3_3c",  3'd0, 8'hC3, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b0);
        step("or_c3_3c",   3'd1, 8'hC3, 8'h3C, 8'hFF, 8'h00, 1'b0, 1'b0);
        step("and_c3_ff",  3'd0, 8'hC3, 8'hFF, 8'hC3, 8'h00, 1'b0, 1'b0);

        step("add_90_20",    3'd2, 8'h5A, 8'h14, 8'h6E, 8'h00, 1'b0, 1'b0);
        step("add_90_90",    3'd2, 8'h5A, 8'h5A, 8'hB4, 8'h02, 1'b0, 1'b0);
        step("add_90_m90",   3'd2, 8'h5A, 8'hA6, 8'h00, 8'h01, 1'b1, 1'b0);
        step("add_m128_m100",3'd2, 8'h80, 8'h9C, 8'h1C, 8'h03, 1'b0, 1'b0);
        step("add_127_127",  3'd2, 8'h7F, 8'h7F, 8'hFE, 8'h02, 1'b0, 1'b0);

        step("srl_2",  3'd3, 8'hF0, 8'd2,  8'h3C, 8'h00, 1'b0, 1'b0);
        step("sra_2",  3'd4, 8'hF0, 8'd2,  8'hFC, 8'h00, 1'b0, 1'b0);
        step("srl_4",  3'd3, 8'hF0, 8'd4,  8'h0F, 8'h00, 1'b0, 1'b0);
        step("sra_4",  3'd4, 8'hF0, 8'd4,  8'hFF, 8'h00, 1'b0, 1'b0);
        step("srl_6",  3'd3, 8'hF0, 8'd6,  8'h03, 8'hC0, 1'b0, 1'b0);
        step("sra_6",  3'd4, 8'hF0, 8'd6,  8'hFF, 8'hC0, 1'b0, 1'b0);
        step("srl_8",  3'd3, 8'hF0, 8'd8,  8'h00, 8'hF0, 1'b1, 1'b0);
        step("sra_8",  3'd4, 8'hF0, 8'd8,  8'hFF, 8'hF0, 1'b0, 1'b0);
        step("srl_14", 3'd3, 8'hF0, 8'd14, 8'h00, 8'h03, 1'b1, 1'b0);
        step("sra_14", 3'd4, 8'hF0, 8'd14, 8'hFF, 8'h03, 1'b0, 1'b0);
        step("srl_16", 3'd3, 8'hF0, 8'd16, 8'h00, 8'h00, 1'b1, 1'b0);
        step("sra_pos_9", 3'd4, 8'h70, 8'd9, 8'h00, 8'h38, 1'b1, 1'b0);

        step("beq_ne",  3'd5, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
        step("beq_eq",  3'd5, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);
        step("addr_10_05", 3'd6, 8'h10, 8'h05, 8'h15, 8'h00, 1'b0, 1'b0);
        step("addr_wrap",  3'd6, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b0, 1'b0);

        // Inputs changing between edges must not disturb the registered outputs.
        #1;
        op = 3'd7; ra_in = 8'h12; rb_in = 8'h34;
        sb.push_back(mk(8'h00, 8'h00, 1'b1, 1'b0));
        #2;
        check("hold_between_edges", last_exp);
        @(posedge clk);
        #1;
        pop_check("op7_after_hold");

        step("op7_ff_ff", 3'd7, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle, then release and reload on the first edge.
        step("pre_reset_add", 3'd2, 8'h7F, 8'h7F, 8'hFE, 8'h02, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", mk(8'h00, 8'h00, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check("reset_held_edge", mk(8'h00, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(8'hFE, 8'h02, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        pop_check("first_after_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
